// File: rtl/regfile_pkg.sv
// Shared types and default sizing for the parametrised register file.
// Optional same-cycle write-to-read forwarding is enabled with REGFILE_BYPASS_EN.
package regfile_pkg;

  localparam int unsigned RF_DATA_W_DEF = 8;
  localparam int unsigned RF_DEPTH_DEF  = 4;

  typedef enum logic [0:0] {
    RF_IDLE  = 1'b0,
    RF_CLEAR = 1'b1
  } rf_state_e;

endpackage

// File: rtl/regfile_clear_seq.sv
// Bulk-clear sequencer: walks every register index once, one per cycle,
// and reports busy for exactly DEPTH cycles.
module regfile_clear_seq
  import regfile_pkg::*;
#(
  parameter int unsigned DEPTH = RF_DEPTH_DEF,
  localparam int unsigned SEL_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             areset_n,
  input  logic             clear_req,
  output logic             clr_we,
  output logic [SEL_W-1:0] clr_addr,
  output logic             busy
);

  localparam logic [SEL_W-1:0] LAST_IDX = SEL_W'(DEPTH - 1);

  rf_state_e        state_q, state_d;
  logic [SEL_W-1:0] idx_q, idx_d;
  logic             busy_q, busy_d;

  // Next state; clear_req is ignored once a clear is running.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    busy_d  = busy_q;
    case (state_q)
      RF_IDLE: begin
        if (clear_req) begin
          state_d = RF_CLEAR;
          idx_d   = '0;
          busy_d  = 1'b1;
        end
      end
      RF_CLEAR: begin
        idx_d = idx_q + SEL_W'(1);
        if (idx_q == LAST_IDX) begin
          state_d = RF_IDLE;
          busy_d  = 1'b0;
        end
      end
      default: begin
        state_d = RF_IDLE;
        idx_d   = '0;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!areset_n) begin
      state_q <= RF_IDLE;
      idx_q   <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      busy_q  <= busy_d;
    end
  end

  assign clr_we   = (state_q == RF_CLEAR);
  assign clr_addr = idx_q;
  assign busy     = busy_q;

endmodule

// File: rtl/regfile_param.sv
// DEPTH x DATA_W register file: two combinational read ports, one write port,
// sequenced bulk clear. Define REGFILE_BYPASS_EN for same-cycle write forwarding.
module regfile_param
  import regfile_pkg::*;
#(
  parameter int unsigned      DATA_W    = RF_DATA_W_DEF,
  parameter int unsigned      DEPTH     = RF_DEPTH_DEF,
  parameter logic [DATA_W-1:0] CLEAR_VAL = '0,
  localparam int unsigned     SEL_W     = $clog2(DEPTH)
) (
  input  logic              CLK,
  input  logic              areset_n,
  input  logic [SEL_W-1:0]  selector_a,
  input  logic [SEL_W-1:0]  selector_b,
  input  logic              write_bit,
  input  logic [SEL_W-1:0]  selector_e,
  input  logic [DATA_W-1:0] data_in,
  input  logic              clear_req,
  output logic [DATA_W-1:0] data_out_a,
  output logic [DATA_W-1:0] data_out_b,
  output logic              busy
);

  logic [DATA_W-1:0] regs_q [DEPTH];
  logic [DATA_W-1:0] regs_d [DEPTH];
  logic              clr_we;
  logic [SEL_W-1:0]  clr_addr;
  logic              wr_en;

  regfile_clear_seq #(
    .DEPTH (DEPTH)
  ) u_clear_seq (
    .clk       (CLK),
    .areset_n  (areset_n),
    .clear_req (clear_req),
    .clr_we    (clr_we),
    .clr_addr  (clr_addr),
    .busy      (busy)
  );

  assign wr_en = write_bit & ~busy;

  // Clear owns the storage while busy; user writes are dropped, not queued.
  always_comb begin
    regs_d = regs_q;
    if (clr_we) begin
      regs_d[clr_addr] = CLEAR_VAL;
    end else if (wr_en) begin
      regs_d[selector_e] = data_in;
    end
  end

  always_ff @(posedge CLK) begin
    if (!areset_n) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      regs_q <= regs_d;
    end
  end

`ifdef REGFILE_BYPASS_EN
  always_comb begin
    data_out_a = regs_q[selector_a];
    data_out_b = regs_q[selector_b];
    if (wr_en && (selector_a == selector_e)) data_out_a = data_in;
    if (wr_en && (selector_b == selector_e)) data_out_b = data_in;
  end
`else
  always_comb begin
    data_out_a = regs_q[selector_a];
    data_out_b = regs_q[selector_b];
  end
`endif

endmodule

// File: tb/tb_regfile_param.sv
// Bench for regfile_param (DATA_W=8, DEPTH=4, CLEAR_VAL=A5): directed vector
// table plus random traffic, every cycle checked against an array-based model.
module tb_regfile_param;

  localparam logic [7:0] CV = 8'hA5;
`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic       CLK = 1'b0;
  logic       areset_n;
  logic [1:0] selector_a, selector_b, selector_e;
  logic       write_bit, clear_req;
  logic [7:0] data_in;
  logic [7:0] data_out_a, data_out_b;
  logic       busy;

  int total = 0;
  int bad   = 0;

  regfile_param #(
    .DATA_W    (8),
    .DEPTH     (4),
    .CLEAR_VAL (CV)
  ) dut (
    .CLK        (CLK),
    .areset_n   (areset_n),
    .selector_a (selector_a),
    .selector_b (selector_b),
    .write_bit  (write_bit),
    .selector_e (selector_e),
    .data_in    (data_in),
    .clear_req  (clear_req),
    .data_out_a (data_out_a),
    .data_out_b (data_out_b),
    .busy       (busy)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic       rst_n;
    logic       we;
    logic [1:0] sel_e;
    logic [7:0] din;
    logic       clr;
    logic [1:0] sel_a;
    logic [1:0] sel_b;
    logic [7:0] exp_a;
    logic [7:0] exp_b;
    logic       exp_busy;
    logic       chk;
  } vec_t;

  // Reference model: plain storage array plus "clear in progress, next slot" counter.
  logic [7:0] m_mem [4];
  bit         m_clearing;
  int         m_pos;

  function automatic vec_t mk(input logic rst_n, input logic we, input logic [1:0] sel_e,
                              input logic [7:0] din, input logic clr, input logic [1:0] sel_a,
                              input logic [1:0] sel_b, input logic [7:0] exp_a,
                              input logic [7:0] exp_b, input logic exp_busy);
    vec_t t;
    t.rst_n = rst_n; t.we = we; t.sel_e = sel_e; t.din = din; t.clr = clr;
    t.sel_a = sel_a; t.sel_b = sel_b; t.exp_a = exp_a; t.exp_b = exp_b;
    t.exp_busy = exp_busy; t.chk = 1'b1;
    return t;
  endfunction

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] model_read(input vec_t t, input logic [1:0] sel);
    if (BYP && t.we && !m_clearing && sel == t.sel_e) return t.din;
    return m_mem[sel];
  endfunction

  task automatic run_cycle(input vec_t t, input string tag);
    areset_n   = t.rst_n;
    write_bit  = t.we;
    selector_e = t.sel_e;
    data_in    = t.din;
    clear_req  = t.clr;
    selector_a = t.sel_a;
    selector_b = t.sel_b;
    @(negedge CLK);
    check({tag, "_mdl_a"}, data_out_a, model_read(t, t.sel_a));
    check({tag, "_mdl_b"}, data_out_b, model_read(t, t.sel_b));
    check({tag, "_mdl_busy"}, {7'd0, busy}, {7'd0, m_clearing});
    if (t.chk) begin
      check({tag, "_a"}, data_out_a, t.exp_a);
      check({tag, "_b"}, data_out_b, t.exp_b);
      check({tag, "_busy"}, {7'd0, busy}, {7'd0, t.exp_busy});
    end
    if (!t.rst_n) begin
      for (int k = 0; k < 4; k++) m_mem[k] = 8'h00;
      m_clearing = 1'b0;
      m_pos = 0;
    end else if (m_clearing) begin
      m_mem[m_pos] = CV;
      m_pos++;
      if (m_pos == 4) m_clearing = 1'b0;
    end else begin
      if (t.we) m_mem[t.sel_e] = t.din;
      if (t.clr) begin
        m_clearing = 1'b1;
        m_pos = 0;
      end
    end
    @(posedge CLK);
    #1;
  endtask

  vec_t vecs[$];
  vec_t r;

  initial begin
    areset_n = 1'b0; write_bit = 1'b0; selector_e = '0; data_in = '0;
    clear_req = 1'b0; selector_a = '0; selector_b = '0;
    @(posedge CLK);
    #1;
    for (int k = 0; k < 4; k++) m_mem[k] = 8'h00;
    m_clearing = 1'b0;
    m_pos = 0;

    //              rst we e  din    clr a  b  exp_a              exp_b             busy
    vecs.push_back(mk(1, 0, 0, 8'h00, 0, 0, 1, 8'h00,             8'h00,            0));
    vecs.push_back(mk(1, 0, 0, 8'h00, 0, 2, 3, 8'h00,             8'h00,            0));
    vecs.push_back(mk(1, 1, 1, 8'h07, 0, 1, 0, BYP ? 8'h07 : 8'h00, 8'h00,          0));
    vecs.push_back(mk(1, 0, 0, 8'h00, 0, 1, 0, 8'h07,             8'h00,            0));
    vecs.push_back(mk(1, 1, 0, 8'h01, 0, 1, 2, 8'h07,             8'h00,            0));
    vecs.push_back(mk(1, 1, 1, 8'h02, 0, 0, 3, 8'h01,             8'h00,            0));
    vecs.push_back(mk(1, 1, 2, 8'h03, 0, 0, 1, 8'h01,             8'h02,            0));
    vecs.push_back(mk(1, 1, 3, 8'h04, 0, 2, 2, 8'h03,             8'h03,            0));
    vecs.push_back(mk(1, 0, 0, 8'h00, 1, 3, 0, 8'h04,             8'h01,            0));
    vecs.push_back(mk(1, 0, 0, 8'h00, 0, 0, 1, 8'h01,             8'h02,            1));
    vecs.push_back(mk(1, 1, 3, 8'h3C, 1, 0, 1, CV,                8'h02,            1));
    vecs.push_back(mk(1, 0, 0, 8'h00, 1, 2, 3, 8'h03,             8'h04,            1));
    vecs.push_back(mk(1, 0, 0, 8'h00, 0, 0, 1, CV,                CV,               1));
    vecs.push_back(mk(1, 0, 0, 8'h00, 0, 2, 3, CV,                CV,               0));
    vecs.push_back(mk(1, 1, 2, 8'h11, 1, 2, 3, BYP ? 8'h11 : CV,  CV,               0));
    vecs.push_back(mk(1, 0, 0, 8'h00, 0, 2, 0, 8'h11,             CV,               1));
    vecs.push_back(mk(1, 0, 0, 8'h00, 0, 2, 1, 8'h11,             CV,               1));
    vecs.push_back(mk(1, 0, 0, 8'h00, 0, 2, 3, 8'h11,             CV,               1));
    vecs.push_back(mk(1, 0, 0, 8'h00, 0, 2, 3, CV,                CV,               1));
    vecs.push_back(mk(1, 0, 0, 8'h00, 0, 2, 3, CV,                CV,               0));
    vecs.push_back(mk(1, 1, 1, 8'h66, 0, 1, 0, BYP ? 8'h66 : CV,  CV,               0));
    vecs.push_back(mk(1, 1, 3, 8'h77, 0, 1, 0, 8'h66,             CV,               0));
    vecs.push_back(mk(1, 0, 0, 8'h00, 1, 1, 3, 8'h66,             8'h77,            0));
    vecs.push_back(mk(1, 0, 0, 8'h00, 0, 0, 1, CV,                8'h66,            1));
    vecs.push_back(mk(0, 0, 0, 8'h00, 0, 1, 3, 8'h66,             8'h77,            1));
    vecs.push_back(mk(1, 0, 0, 8'h00, 0, 1, 3, 8'h00,             8'h00,            0));
    vecs.push_back(mk(1, 0, 0, 8'h00, 0, 0, 2, 8'h00,             8'h00,            0));
    vecs.push_back(mk(1, 1, 0, 8'h12, 1, 0, 3, BYP ? 8'h12 : 8'h00, 8'h00,          0));
    vecs.push_back(mk(1, 0, 0, 8'h00, 0, 0, 1, 8'h12,             8'h00,            1));
    vecs.push_back(mk(1, 0, 0, 8'h00, 0, 0, 1, CV,                8'h00,            1));
    vecs.push_back(mk(1, 0, 0, 8'h00, 0, 1, 2, CV,                8'h00,            1));
    vecs.push_back(mk(1, 0, 0, 8'h00, 0, 2, 3, CV,                8'h00,            1));
    vecs.push_back(mk(1, 0, 0, 8'h00, 0, 3, 0, CV,                CV,               0));

    for (int i = 0; i < vecs.size(); i++) begin
      run_cycle(vecs[i], $sformatf("row%0d", i));
    end

    for (int n = 0; n < 400; n++) begin
      r.rst_n = ($urandom_range(0, 40) != 0);
      r.we    = 1'($urandom_range(0, 1));
      r.sel_e = 2'($urandom_range(0, 3));
      r.din   = 8'($urandom);
      r.clr   = ($urandom_range(0, 12) == 0);
      r.sel_a = 2'($urandom_range(0, 3));
      r.sel_b = 2'($urandom_range(0, 3));
      r.exp_a = 8'h00; r.exp_b = 8'h00; r.exp_busy = 1'b0;
      r.chk   = 1'b0;
      run_cycle(r, $sformatf("rnd%0d", n));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
